alu_serial: RTL
===============

Name: alu_serial

Overview:
- Bit-serial 32-bit ALU controller that drives one instance of the existing 1-bit ALU slice (alu_top), LSB first, over WIDTH cycles.
- It is the initiator side of the slice interface. It sequences src1/src2/less/A_invert/B_invert/cin/operation into the slice and collects result/cout back.
- Flags and the full result word are assembled afterwards.
- Used where area matters more than latency: a multi-cycle datapath or a microcoded control unit.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  request a new operation; sampled in IDLE only.
- src1_i  input  WIDTH  operand A; latched on an accepted start.
- src2_i  input  WIDTH  operand B; latched on an accepted start.
- ALU_control_i  input  4  {A_invert, B_invert, operation[1:0]}; latched on an accepted start.
- busy_o  output  1  high from the cycle after accept until done_o is asserted.
- done_o  output  1  one-cycle pulse when result_o and the flags are valid.
- result_o  output  WIDTH  final result; held until the next done_o.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  carry out of the MSB. Valid only for arithmetic ops (operation==2'b10 or 2'b11); 0 otherwise.
- overflow_o  output  1  carry into MSB XOR carry out of MSB. Valid only for arithmetic ops; 0 otherwise.

Behaviour:
- Encodings:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111.
  - NAND 1101 is also legal.
  - Any other code is executed literally through the slice.
- Reset: state=IDLE; bit counter=0; busy_o=0; done_o=0; result_o=0; zero_o=0; cout_o=0; overflow_o=0.
- FSM IDLE:
  - start_i=1 latches the operands and the control word, loads carry := B_invert, clears the counter, and goes to RUN.
  - start_i=0 stays in IDLE.
- FSM RUN:
  - Each cycle the slice gets bit[cnt] of both operands, the registered carry as cin, and less=0.
  - The slice result is shifted into the result shift register from the top, so LSB-first assembly ends aligned.
  - The carry register takes cout.
  - Before the MSB cycle updates the carry, the carry into the MSB is captured.
  - On the MSB cycle (cnt==WIDTH-1), go to FIN.
- FSM FIN:
  - set = sum_msb XOR overflow.
  - If operation==2'b11 (SLT), the result is {WIDTH-1 zeros, set}. The less path is resolved here, not in RUN.
  - Register result_o, zero_o, cout_o and overflow_o.
  - done_o=1 for this cycle only, busy_o=0; then go to IDLE.
- Latency: start accepted at edge T → done_o high in cycle T+WIDTH+1 (33 cycles for WIDTH=32).
- Back-to-back:
  - start_i is ignored while busy_o=1. Operands presented then are dropped, and the latched ones are unaffected.
  - start_i in the cycle where done_o=1 is also ignored. The earliest new accept is the cycle after done_o.
- Reset mid-operation: aborts the operation with no done_o pulse. All outputs return to their reset values, including any previously held result_o.
- Carry chain is purely internal. cin for bit 0 equals B_invert, so SUB and SLT perform two's-complement subtraction.
- No output changes during RUN except busy_o.

Decomposition:
- Shared package alu_pkg:
  - ALU_control constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT, ALU_NAND).
  - Op-field constant OP_SLT=2'b11.
  - State enum {S_IDLE, S_RUN, S_FIN}.
- One sub-module, instantiated unchanged: alu_top (the 1-bit slice).
- All sequencing, shift registers and flag logic live in alu_serial.

Test Plan:
- ADD 7 + 5, start at cycle 0 → busy_o high cycles 1..32; done_o pulse at cycle 33; result_o=12, zero_o=0, cout_o=0, overflow_o=0.
- SUB 5 − 7 → result_o=0xFFFFFFFE, cout_o=0, overflow_o=0; then SUB 7 − 7 → result_o=0, zero_o=1, cout_o=1.
- ADD 0x7FFFFFFF + 1 → result_o=0x80000000, overflow_o=1, cout_o=0; SLT 0x80000000 < 1 → result_o=1 (overflow-corrected set).
- NOR 0, 0 → result_o=0xFFFFFFFF, cout_o=0, overflow_o=0; AND 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000.
- Start ADD 1 + 1, then pulse start_i with SUB 9 − 3 at cycle 10 → ignored; done at cycle 33 with result_o=2, no second done_o.
- Start ADD 3 + 4, assert rst_i at cycle 15 → no done_o; at cycle 16 busy_o=0 and result_o=0; a new start then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: control-word encodings, SLT op field and controller state for the serial ALU
package alu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NAND = 4'b1101;
  localparam logic [1:0] OP_SLT   = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
endpackage

// File: rtl/alu_top.sv
// alu_top: 1-bit ALU slice with operand inversion, carry in/out and a less input
module alu_top (
  input  logic       src1,
  input  logic       src2,
  input  logic       less,
  input  logic       A_invert,
  input  logic       B_invert,
  input  logic       cin,
  input  logic [1:0] operation,
  output logic       result,
  output logic       cout
);
  logic w_a, w_b;
  assign w_a = src1 ^ A_invert;
  assign w_b = src2 ^ B_invert;
  assign result = operation == 2'b00 ? w_a & w_b :
                  operation == 2'b01 ? w_a | w_b :
                  operation == 2'b10 ? w_a ^ w_b ^ cin : less;
  assign cout = (w_a & w_b) | (w_a & cin) | (w_b & cin);
endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU controller driving one alu_top slice LSB first over WIDTH cycles
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_sr;
  logic [3:0]       r_ctl;
  logic             r_carry;
  logic             w_res, w_cout, w_last, w_sum, w_ovf;
  logic [WIDTH-1:0] w_word, w_final;

  alu_top u_slice (
    .src1     (r_a[0]),
    .src2     (r_b[0]),
    .less     (1'b0),
    .A_invert (r_ctl[3]),
    .B_invert (r_ctl[2]),
    .cin      (r_carry),
    .operation(r_ctl[1:0]),
    .result   (w_res),
    .cout     (w_cout)
  );

  // Flags are resolved combinationally on the MSB cycle so they land with done_o
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_word  = {w_res, r_sr};
  assign w_ovf   = r_carry ^ w_cout;
  assign w_sum   = r_a[0] ^ r_ctl[3] ^ r_b[0] ^ r_ctl[2] ^ r_carry;
  assign w_final = r_ctl[1:0] == OP_SLT ? {{(WIDTH-1){1'b0}}, w_sum ^ w_ovf} : w_word;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state == S_IDLE ? (start_i ? S_RUN : S_IDLE) :
             r_state == S_RUN  ? (w_last ? S_FIN : S_RUN) : S_IDLE;
  end

  always_comb begin
    busy_o = r_state == S_RUN;
    done_o = r_state == S_FIN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sr       <= '0;
      r_ctl      <= '0;
      r_carry    <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (r_state == S_IDLE && start_i) begin
      r_a     <= src1_i;
      r_b     <= src2_i;
      r_ctl   <= ALU_control_i;
      r_carry <= ALU_control_i[2];
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sr    <= w_word[WIDTH-1:1];
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        result_o   <= w_final;
        zero_o     <= w_final == '0;
        cout_o     <= r_ctl[1] & w_cout;
        overflow_o <= r_ctl[1] & w_ovf;
      end
    end
  end
endmodule
